// File: rtl/aftab_sgn_multiplier_if.sv
// Request/response bundle for the AAU shift-add multiplier.
// The AAU controller drives the operands and start; the multiplier returns Product and ready.
interface aftab_sgn_multiplier_if #(parameter int len = 33);
  logic [len-1:0]   A;
  logic [len-1:0]   B;
  logic             start;
  logic             SignedFlag;
  logic [2*len-1:0] Product;
  logic             ready;

  modport master (output A, B, start, SignedFlag, input Product, ready);
  modport slave  (input A, B, start, SignedFlag, output Product, ready);
endinterface

// File: rtl/aftab_sgn_multiplier.sv
// Sequential signed/unsigned shift-add multiplier: len iterations on operand magnitudes,
// then a single two's-complement fixup cycle, with a one-cycle ready pulse.
module aftab_sgn_multiplier #(
  parameter int len = 33
) (
  input logic clk,
  input logic rst,
  aftab_sgn_multiplier_if.slave bus
);
  localparam int CW = $clog2(len + 1);

  typedef enum logic [1:0] {IDLE, MULT, SIGN, DONE} state_t;

  state_t           state, state_nxt;
  logic [len-1:0]   mag_a, mag_b, abs_a, abs_b;
  logic [2*len-1:0] acc, addend, product;
  logic [CW-1:0]    cnt;
  logic             sgn, ready, last;

  // Negating the most negative value wraps to 2^(len-1), which is the correct unsigned magnitude.
  always_comb begin
    abs_a  = (bus.SignedFlag && bus.A[len-1]) ? -bus.A : bus.A;
    abs_b  = (bus.SignedFlag && bus.B[len-1]) ? -bus.B : bus.B;
    addend = {{len{1'b0}}, mag_a} << cnt;
    last   = (cnt == CW'(len - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = MULT;
      MULT: if (last)      state_nxt = SIGN;
      SIGN:                state_nxt = DONE;
      DONE: if (!bus.start) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      cnt     <= '0;
      sgn     <= 1'b0;
      product <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= (state == SIGN);
      case (state)
        IDLE: if (bus.start) begin
          sgn   <= bus.SignedFlag & (bus.A[len-1] ^ bus.B[len-1]);
          mag_a <= abs_a;
          mag_b <= abs_b;
          acc   <= '0;
          cnt   <= '0;
        end
        MULT: begin
          if (mag_b[0]) acc <= acc + addend;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + 1'b1;
        end
        SIGN: product <= sgn ? -acc : acc;
        default: ;
      endcase
    end
  end

  assign bus.Product = product;
  assign bus.ready   = ready;
endmodule
